// File: rtl/game_autoplay_sequencer.sv
// game_autoplay_sequencer
//   Autoplay driver for the blackjack controller. It sweeps a range of seeds
//   and hit counts. Each game is played through the controller's active-low
//   buttons, and the outcomes are tallied on chip.
//
//   Per game:
//     controller reset pulse -> boot wait -> ready pulse
//       -> (hit pulse + gap) x cur_hits -> stand pulse
//       -> wait for outcome (or timeout) -> record -> next
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   start_i              1-cycle pulse, begins a run (ignored while busy)
//   abort_i              level, stops the run and returns to idle (beats start_i)
//   mode_i               0: sweep hits 0..MAX_HITS per seed, 1: fixed_hits_i only
//   fixed_hits_i         hit count for mode 1 (clamped to MAX_HITS)
//   seed_first_i/_last_i inclusive seed range; wraps through the maximum seed
//   game_outcome_i       00 pending, 01 player win, 10 house win, 11 push
//   ctl_rst_n_o          controller reset (active-low)
//   ready_n_o, hit_n_o, stand_n_o  controller buttons (active-low)
//   seed_o, cur_hits_o   seed and planned hit count of the current game
//   busy_o, done_o       run in progress / 1-cycle completion pulse
//   *_cnt_o              saturating outcome tallies
module game_autoplay_sequencer #(
  parameter int SEED_W    = 6,
  parameter int MAX_HITS  = 3,
  parameter int PULSE_CYC = 10,
  parameter int GAP_CYC   = 10,
  parameter int BOOT_CYC  = 350,
  parameter int TIMEOUT   = 1000,
  parameter int CNT_W     = 16,
  localparam int HW = (MAX_HITS > 0) ? $clog2(MAX_HITS + 1) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic              mode_i,
  input  logic [HW-1:0]     fixed_hits_i,
  input  logic [SEED_W-1:0] seed_first_i,
  input  logic [SEED_W-1:0] seed_last_i,
  input  logic [1:0]        game_outcome_i,
  output logic              ctl_rst_n_o,
  output logic              ready_n_o,
  output logic              hit_n_o,
  output logic              stand_n_o,
  output logic [SEED_W-1:0] seed_o,
  output logic [HW-1:0]     cur_hits_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  win_cnt_o,
  output logic [CNT_W-1:0]  lose_cnt_o,
  output logic [CNT_W-1:0]  push_cnt_o,
  output logic [CNT_W-1:0]  timeout_cnt_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_RST_LOW, S_BOOT, S_READY_LOW, S_GAP, S_HIT_LOW,
    S_STAND_LOW, S_WAIT_RESULT, S_RECORD, S_NEXT, S_DONE
  } state_e;

  // One shared interval counter, sized for the longest timed state.
  localparam int M1      = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int M2      = (M1 > BOOT_CYC) ? M1 : BOOT_CYC;
  localparam int CYC_MAX = (M2 > TIMEOUT) ? M2 : TIMEOUT;
  localparam int CW      = $clog2(CYC_MAX + 1);

  localparam logic [CW-1:0] PULSE_END = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] GAP_END   = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0] BOOT_END  = CW'(BOOT_CYC - 1);
  localparam logic [CW-1:0] TO_END    = CW'(TIMEOUT - 1);
  localparam logic [HW-1:0] HITS_MAX  = HW'(MAX_HITS);

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [SEED_W-1:0]   seed_q, seed_d, seed_last_q, seed_last_d;
  logic                mode_q, mode_d;
  logic [HW-1:0]       fixed_q, fixed_d, cur_hits_q, cur_hits_d, hits_q, hits_d;
  logic [1:0]          result_q, result_d;
  logic [CNT_W-1:0]    win_q, win_d, lose_q, lose_d, push_q, push_d, to_q, to_d;
  logic                ctl_rst_n_q, ready_n_q, hit_n_q, stand_n_q, busy_q, done_q;

  always_comb begin
    // NOTE: every variable gets a default before the case so that no path
    // leaves it unassigned and no latch is inferred.
    state_d     = state_q;
    cnt_d       = '0;
    seed_d      = seed_q;
    seed_last_d = seed_last_q;
    mode_d      = mode_q;
    fixed_d     = fixed_q;
    cur_hits_d  = cur_hits_q;
    hits_d      = hits_q;
    result_d    = result_q;
    win_d       = win_q;
    lose_d      = lose_q;
    push_d      = push_q;
    to_d        = to_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_i && !abort_i) begin
          seed_d      = seed_first_i;
          seed_last_d = seed_last_i;
          mode_d      = mode_i;
          fixed_d     = (fixed_hits_i > HITS_MAX) ? HITS_MAX : fixed_hits_i;
          cur_hits_d  = mode_i ? ((fixed_hits_i > HITS_MAX) ? HITS_MAX : fixed_hits_i) : '0;
          win_d       = '0;
          lose_d      = '0;
          push_d      = '0;
          to_d        = '0;
          state_d     = S_RST_LOW;
        end
      end
      S_RST_LOW: begin
        if (cnt_q == PULSE_END) state_d = S_BOOT;
        else                    cnt_d   = cnt_q + 1'b1;
      end
      S_BOOT: begin
        if (cnt_q == BOOT_END) state_d = S_READY_LOW;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      S_READY_LOW: begin
        hits_d = '0;
        if (cnt_q == PULSE_END) state_d = S_GAP;
        else                    cnt_d   = cnt_q + 1'b1;
      end
      S_GAP: begin
        // The gap follows the ready pulse and every hit pulse. It either
        // issues another hit or moves on to stand.
        if (cnt_q == GAP_END) state_d = (hits_q < cur_hits_q) ? S_HIT_LOW : S_STAND_LOW;
        else                  cnt_d   = cnt_q + 1'b1;
      end
      S_HIT_LOW: begin
        if (cnt_q == PULSE_END) begin
          hits_d  = hits_q + 1'b1;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STAND_LOW: begin
        if (cnt_q == PULSE_END) state_d = S_WAIT_RESULT;
        else                    cnt_d   = cnt_q + 1'b1;
      end
      S_WAIT_RESULT: begin
        // A result code of 00 is recorded as a timeout.
        if (game_outcome_i != 2'b00) begin
          result_d = game_outcome_i;
          state_d  = S_RECORD;
        end else if (cnt_q == TO_END) begin
          result_d = 2'b00;
          state_d  = S_RECORD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RECORD: begin
        unique case (result_q)
          2'b01:   if (win_q  != '1) win_d  = win_q  + 1'b1;
          2'b10:   if (lose_q != '1) lose_d = lose_q + 1'b1;
          2'b11:   if (push_q != '1) push_d = push_q + 1'b1;
          default: if (to_q   != '1) to_d   = to_q   + 1'b1;
        endcase
        state_d = S_NEXT;
      end
      S_NEXT: begin
        if (!mode_q && (cur_hits_q < HITS_MAX)) begin
          cur_hits_d = cur_hits_q + 1'b1;
          state_d    = S_RST_LOW;
        end else if (seed_q == seed_last_q) begin
          state_d = S_DONE;
        end else begin
          seed_d     = seed_q + 1'b1;  // wraps naturally at 2^SEED_W
          cur_hits_d = mode_q ? fixed_q : '0;
          state_d    = S_RST_LOW;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (abort_i && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      seed_q      <= '0;
      seed_last_q <= '0;
      mode_q      <= 1'b0;
      fixed_q     <= '0;
      cur_hits_q  <= '0;
      hits_q      <= '0;
      result_q    <= 2'b00;
      win_q       <= '0;
      lose_q      <= '0;
      push_q      <= '0;
      to_q        <= '0;
      ctl_rst_n_q <= 1'b1;
      ready_n_q   <= 1'b1;
      hit_n_q     <= 1'b1;
      stand_n_q   <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments, so every flop
      // samples the pre-edge values and ordering inside the block is irrelevant.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      seed_q      <= seed_d;
      seed_last_q <= seed_last_d;
      mode_q      <= mode_d;
      fixed_q     <= fixed_d;
      cur_hits_q  <= cur_hits_d;
      hits_q      <= hits_d;
      result_q    <= result_d;
      win_q       <= win_d;
      lose_q      <= lose_d;
      push_q      <= push_d;
      to_q        <= to_d;
      // Button outputs are registered from the next state, which keeps them
      // glitch-free. At most one of them can be low at a time.
      ctl_rst_n_q <= (state_d != S_RST_LOW);
      ready_n_q   <= (state_d != S_READY_LOW);
      hit_n_q     <= (state_d != S_HIT_LOW);
      stand_n_q   <= (state_d != S_STAND_LOW);
      busy_q      <= (state_d != S_IDLE) && (state_d != S_DONE);
      done_q      <= (state_d == S_DONE);
    end
  end

  assign ctl_rst_n_o   = ctl_rst_n_q;
  assign ready_n_o     = ready_n_q;
  assign hit_n_o       = hit_n_q;
  assign stand_n_o     = stand_n_q;
  assign seed_o        = seed_q;
  assign cur_hits_o    = cur_hits_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign win_cnt_o     = win_q;
  assign lose_cnt_o    = lose_q;
  assign push_cnt_o    = push_q;
  assign timeout_cnt_o = to_q;

endmodule
